// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce stimulus/response path.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BOUNCE_IN  = 2'd1,
    HOLD       = 2'd2,
    BOUNCE_OUT = 2'd3
  } bounce_state_t;

  // Fibonacci feedback taps 16,14,13,11 (bit 15 is tap 16)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One shift of the 16-bit Fibonacci LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; a zero seed is replaced by DEFAULT_SEED so the
// register can never lock up in the all-zero state.
module lfsr16
  import debounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_seed;

  assign w_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  // Shift register: loads seed on reset, advances only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= w_seed;
    end else if (en) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical-button emulator: one press_req pulse produces chatter-in,
// a stable-high hold and chatter-out on button_out.
// Build option BOUNCE_GEN_RANDOM_EN: LFSR-driven toggle gaps; when undefined
// the gap is a fixed 2**GAP_W cycles and no LFSR is built.
module button_bounce_gen
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned BOUNCE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES   = 5000000,
  parameter int unsigned GAP_W         = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_req,
  output logic button_out,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);

  bounce_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt, w_phase_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic [GAP_W-1:0] w_gap_load;
  logic             r_button, w_button_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] w_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_busy),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  assign w_gap_load = w_lfsr[GAP_W-1:0];
`else
  assign w_gap_load = '1;
`endif

  // State and output registers; reset aborts any sequence with no done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase_cnt <= '0;
      r_gap_cnt   <= '0;
      r_button    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_button    <= w_button_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and registered-output logic; phase expiry overrides gap expiry
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_button_nxt = r_button;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        // the done cycle still counts as busy for request acceptance
        if (press_req && !r_done) begin
          w_state_nxt  = BOUNCE_IN;
          w_button_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_phase_nxt  = BOUNCE_LOAD;
          w_gap_nxt    = w_gap_load;
        end
      end

      BOUNCE_IN, BOUNCE_OUT: begin
        if (r_phase_cnt == '0) begin
          if (r_state == BOUNCE_IN) begin
            w_state_nxt  = HOLD;
            w_button_nxt = 1'b1;
            w_phase_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt  = IDLE;
            w_button_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_ONE;
          if (r_gap_cnt == '0) begin
            w_button_nxt = ~r_button;
            w_gap_nxt    = w_gap_load;
          end else begin
            w_gap_nxt = r_gap_cnt - GAP_ONE;
          end
        end
      end

      HOLD: begin
        w_button_nxt = 1'b1;
        if (r_phase_cnt == '0) begin
          w_state_nxt  = BOUNCE_OUT;
          w_button_nxt = 1'b0;
          w_phase_nxt  = BOUNCE_LOAD;
          w_gap_nxt    = w_gap_load;
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_button_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign button_out = r_button;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
